// File: rtl/de1_soc_qsys_pio_bidir.sv
// rtl/de1_soc_qsys_pio_bidir.sv - Avalon-MM bidirectional PIO with direction, edge capture and maskable irq
// Optional PIO_BIT_SETCLR_EN adds write-only OUTSET (addr 4) and OUTCLR (addr 5) registers.
module de1_soc_qsys_pio_bidir #(
    parameter int               WIDTH       = 8,
    parameter int               EDGE_TYPE   = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter logic [WIDTH-1:0] DIR_RESET   = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic [WIDTH-1:0] oe_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef PIO_BIT_SETCLR_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    logic [WIDTH-1:0] data_out;
    logic [WIDTH-1:0] dir;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecap;
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] sync3;
    logic [WIDTH-1:0] edge_det;
    logic [WIDTH-1:0] edge_clr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             wr_strobe;

    assign wr_strobe = chipselect && !write_n;
    assign wdata     = writedata[WIDTH-1:0];

    generate
        if (WIDTH < 32) begin : g_unused_wdata
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    // sync3 is only the previous value of sync2, kept for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= '0;
            sync2 <= '0;
            sync3 <= '0;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign edge_det = sync2 & ~sync3;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign edge_det = ~sync2 & sync3;
        end else begin : g_any
            assign edge_det = sync2 ^ sync3;
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= RESET_VALUE;
        end else if (wr_strobe) begin
            case (address)
                ADDR_DATA:   data_out <= wdata;
`ifdef PIO_BIT_SETCLR_EN
                ADDR_OUTSET: data_out <= data_out | wdata;
                ADDR_OUTCLR: data_out <= data_out & ~wdata;
`endif
                default:     data_out <= data_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dir     <= DIR_RESET;
            irqmask <= '0;
        end else if (wr_strobe) begin
            if (address == ADDR_DIR) begin
                dir <= wdata;
            end
            if (address == ADDR_IRQMASK) begin
                irqmask <= wdata;
            end
        end
    end

    assign edge_clr = (wr_strobe && address == ADDR_EDGECAP) ? wdata : '0;

    // OR-ing the new edge after the clear lets a same-cycle edge win
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edgecap <= '0;
        end else begin
            edgecap <= (edgecap & ~edge_clr) | edge_det;
        end
    end

    always_comb begin
        rdata = '0;
        case (address)
            ADDR_DATA:    rdata = (dir & data_out) | (~dir & sync2);
            ADDR_DIR:     rdata = dir;
            ADDR_IRQMASK: rdata = irqmask;
            ADDR_EDGECAP: rdata = edgecap;
            default:      rdata = '0;
        endcase
    end

    assign readdata = 32'(rdata);
    assign out_port = data_out;
    assign oe_port  = dir;
    assign irq      = |(edgecap & irqmask);

endmodule

// File: tb/tb_de1_soc_qsys_pio_bidir.sv
// tb/tb_de1_soc_qsys_pio_bidir.sv - scoreboard bench for de1_soc_qsys_pio_bidir
module tb_de1_soc_qsys_pio_bidir;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic [7:0]  out_port;
    logic [7:0]  oe_port;
    logic        irq;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    de1_soc_qsys_pio_bidir #(
        .WIDTH       (8),
        .EDGE_TYPE   (0),
        .RESET_VALUE (8'hA5),
        .DIR_RESET   (8'h0F)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .out_port   (out_port),
        .oe_port    (oe_port),
        .irq        (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_check(input logic [31:0] got);
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard_empty: got %h expected an entry", got);
        end else begin
            check(tag_q.pop_front(), got, exp_q.pop_front());
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic read_expect(input string tag, input logic [2:0] a, input logic [31:0] exp);
        sb_push(tag, exp);
        @(negedge clk);
        address    = a;
        chipselect = 1'b1;
        #1;
        sb_check(readdata);
        chipselect = 1'b0;
    endtask

    task automatic sig_expect(input string tag, input logic [31:0] got, input logic [31:0] exp);
        sb_push(tag, exp);
        sb_check(got);
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 8'h00;
        #12;
        sig_expect("rst_out_port", {24'b0, out_port}, 32'hA5);
        sig_expect("rst_oe_port",  {24'b0, oe_port},  32'h0F);
        sig_expect("rst_irq",      {31'b0, irq},      32'h0);
        wait_cycles(2);
        @(negedge clk);
        reset_n = 1'b1;

        read_expect("rst_data",    3'd0, 32'h05);
        read_expect("rst_dir",     3'd1, 32'h0F);
        read_expect("rst_irqmask", 3'd2, 32'h00);
        read_expect("rst_edgecap", 3'd3, 32'h00);

        // mixed direction readback
        bus_write(3'd1, 32'hFFFF_FFF0);
        bus_write(3'd0, 32'h0000_003C);
        sig_expect("dir_oe_port", {24'b0, oe_port}, 32'hF0);
        @(negedge clk);
        in_port = 8'h0A;
        wait_cycles(2);
        read_expect("mixed_data", 3'd0, 32'h3A);
        sig_expect("mixed_out_port", {24'b0, out_port}, 32'h3C);
        read_expect("rise_cap_0a", 3'd3, 32'h0A);

        bus_write(3'd3, 32'hFF);
        read_expect("edgecap_cleared", 3'd3, 32'h00);
        bus_write(3'd2, 32'h01);
        read_expect("irqmask_rb", 3'd2, 32'h01);
        bus_write(3'd7, 32'hFF);
        read_expect("unmapped_read", 3'd7, 32'h00);
        read_expect("unmapped_dir_kept", 3'd1, 32'hF0);

        // input latency: edge registered at E2
        @(negedge clk);
        in_port = 8'h0B;
        @(posedge clk);
        @(posedge clk);
        #1;
        sig_expect("irq_before_e2", {31'b0, irq}, 32'h0);
        read_expect("cap_before_e2", 3'd3, 32'h00);
        @(posedge clk);
        #1;
        sig_expect("irq_after_e2", {31'b0, irq}, 32'h1);
        read_expect("cap_after_e2", 3'd3, 32'h01);
        bus_write(3'd3, 32'h01);
        sig_expect("irq_cleared", {31'b0, irq}, 32'h0);

        @(negedge clk);
        in_port = 8'h0A;
        wait_cycles(4);
        read_expect("fall_not_cap", 3'd3, 32'h00);
        @(negedge clk);
        in_port = 8'h0B;
        wait_cycles(4);
        bus_write(3'd3, 32'h00);
        read_expect("w0_no_effect", 3'd3, 32'h01);
        @(negedge clk);
        in_port = 8'h0A;
        wait_cycles(4);

        // clear and a new edge land on the same edge: set wins
        @(negedge clk);
        in_port = 8'h0B;
        @(posedge clk);
        @(posedge clk);
        bus_write(3'd3, 32'h01);
        read_expect("set_wins_cap", 3'd3, 32'h01);
        sig_expect("set_wins_irq", {31'b0, irq}, 32'h1);
        bus_write(3'd3, 32'h01);
        read_expect("clear_after", 3'd3, 32'h00);

        bus_write(3'd0, 32'h0F);
        bus_write(3'd4, 32'h30);
        bus_write(3'd5, 32'h01);
`ifdef PIO_BIT_SETCLR_EN
        sig_expect("setclr_out_port", {24'b0, out_port}, 32'h3E);
`else
        sig_expect("setclr_out_port", {24'b0, out_port}, 32'h0F);
`endif
        read_expect("outset_reads_0", 3'd4, 32'h00);
        read_expect("outclr_reads_0", 3'd5, 32'h00);

        // all bits captured, then asynchronous reset between edges
        @(negedge clk);
        in_port = 8'h00;
        wait_cycles(4);
        @(negedge clk);
        in_port = 8'hFF;
        wait_cycles(4);
        bus_write(3'd2, 32'hFF);
        read_expect("cap_all", 3'd3, 32'hFF);
        sig_expect("irq_all", {31'b0, irq}, 32'h1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        sig_expect("async_irq_drop", {31'b0, irq}, 32'h0);
        sig_expect("async_out_port", {24'b0, out_port}, 32'hA5);
        sig_expect("async_oe_port",  {24'b0, oe_port},  32'h0F);
        read_expect("async_data",    3'd0, 32'h05);
        read_expect("async_dir",     3'd1, 32'h0F);
        read_expect("async_irqmask", 3'd2, 32'h00);
        read_expect("async_edgecap", 3'd3, 32'h00);
        @(negedge clk);
        reset_n = 1'b1;
        wait_cycles(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
